// File: rtl/galois_lsfr_checker_pkg.sv
// Shared types and Galois LFSR helpers for the sequence checker.
package galois_lsfr_checker_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } chk_state_t;

   localparam int MAX_W = 128;

   function automatic bit width_ok(input int w);
      return ((w >= 3) && (w <= 20)) || (w == 32) || (w == 64) || (w == 128);
   endfunction

   // Feedback tap positions for maximal-length sequences, one mask per width.
   function automatic logic [MAX_W-1:0] tap_mask(input int w);
      logic [MAX_W-1:0] t;
      t = '0;
      case (w)
         3:   t[2] = 1'b1;
         4:   t[3] = 1'b1;
         5:   t[3] = 1'b1;
         6:   t[5] = 1'b1;
         7:   t[6] = 1'b1;
         8:   begin t[6] = 1'b1; t[5] = 1'b1; t[4] = 1'b1; end
         9:   t[5] = 1'b1;
         10:  t[7] = 1'b1;
         11:  t[9] = 1'b1;
         12:  begin t[6] = 1'b1; t[4] = 1'b1; t[1] = 1'b1; end
         13:  begin t[4] = 1'b1; t[3] = 1'b1; t[1] = 1'b1; end
         14:  begin t[5] = 1'b1; t[3] = 1'b1; t[1] = 1'b1; end
         15:  t[14] = 1'b1;
         16:  begin t[15] = 1'b1; t[13] = 1'b1; t[4] = 1'b1; end
         17:  t[14] = 1'b1;
         18:  t[11] = 1'b1;
         19:  begin t[6] = 1'b1; t[2] = 1'b1; t[1] = 1'b1; end
         20:  t[17] = 1'b1;
         32:  begin t[22] = 1'b1; t[2] = 1'b1; t[1] = 1'b1; end
         64:  begin t[63] = 1'b1; t[61] = 1'b1; t[60] = 1'b1; end
         128: begin t[126] = 1'b1; t[101] = 1'b1; t[99] = 1'b1; end
         default: t = '0;
      endcase
      return t;
   endfunction

   // One Galois step on the low w bits: rotate left, then xor taps when the msb was set.
   function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] d, input int w);
      logic [MAX_W-1:0] r;
      logic             msb;
      msb = d[w-1];
      r   = '0;
      for (int k = 1; k < MAX_W; k++) begin
         if (k < w) r[k] = d[k-1];
      end
      r[0] = msb;
      if (msb) r = r ^ tap_mask(w);
      return r;
   endfunction

endpackage

// File: rtl/galois_lsfr_checker_popcount.sv
// Combinational population count of a word (bit errors in one received word).
module lsfr_popcount #(
   parameter int BIT_WIDTH = 8,
   localparam int CW = $clog2(BIT_WIDTH + 1)
) (
   input  logic [BIT_WIDTH-1:0] data,
   output logic [CW-1:0]        count
);

   // Sum the set bits.
   always_comb begin
      count = '0;
      for (int i = 0; i < BIT_WIDTH; i++) begin
         count = count + CW'(data[i]);
      end
   end

endmodule

// File: rtl/galois_lsfr_checker.sv
// Galois LFSR sequence checker: locks onto a received sequence, then flywheels the
// prediction and accumulates word/bit error statistics.
//
// state  | meaning
// SEARCH | waiting for a nonzero valid word to seed the predictor
// VERIFY | counting consecutive correct predictions before declaring lock
// LOCKED | free-running predictor, errors counted, lock lost on a run of misses
module galois_lsfr_checker
   import galois_lsfr_checker_pkg::*;
#(
   parameter int BIT_WIDTH  = 8,
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 4,
   parameter int CNT_W      = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 clr_cnt,
   input  logic                 rx_vld,
   input  logic [BIT_WIDTH-1:0] rx_data,
   output logic                 locked,
   output logic                 err_evt,
   output logic [CNT_W-1:0]     word_cnt,
   output logic [CNT_W-1:0]     word_err_cnt,
   output logic [CNT_W-1:0]     bit_err_cnt,
   output logic                 period_done
);

   localparam int PW = $clog2(BIT_WIDTH + 1);
   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int UW = $clog2(UNLOCK_CNT + 1);
   localparam logic [MW-1:0] LOCK_LAST   = MW'(LOCK_CNT - 1);
   localparam logic [UW-1:0] UNLOCK_LAST = UW'(UNLOCK_CNT - 1);

   if (!width_ok(BIT_WIDTH)) begin : g_bad_width
      $error("galois_lsfr_checker: unsupported BIT_WIDTH %0d", BIT_WIDTH);
   end
   if (LOCK_CNT < 1 || UNLOCK_CNT < 1) begin : g_bad_cnt
      $error("galois_lsfr_checker: LOCK_CNT and UNLOCK_CNT must be >= 1");
   end

   function automatic logic [BIT_WIDTH-1:0] next_w(input logic [BIT_WIDTH-1:0] d);
      logic [MAX_W-1:0] wide;
      wide                 = '0;
      wide[BIT_WIDTH-1:0]  = d;
      wide                 = lfsr_next(wide, BIT_WIDTH);
      return wide[BIT_WIDTH-1:0];
   endfunction

   chk_state_t           state, state_nx;
   logic [BIT_WIDTH-1:0] pred, pred_nx;
   logic [BIT_WIDTH-1:0] ref_word, ref_nx;
   logic [MW-1:0]        match_cnt, match_nx;
   logic [UW-1:0]        miss_cnt, miss_nx;
   logic                 err_nx, period_nx;
   logic                 word_inc, err_inc;
   logic                 mismatch;
   logic [PW-1:0]        pop;
   logic [CNT_W:0]       bit_sum;

   lsfr_popcount #(.BIT_WIDTH(BIT_WIDTH)) u_popcount (
      .data  (rx_data ^ pred),
      .count (pop)
   );

   assign mismatch = (rx_data != pred);
   assign bit_sum  = {1'b0, bit_err_cnt} + (CNT_W + 1)'(pop);

   // Next-state, predictor and event decode; only valid words advance the FSM.
   always_comb begin
      state_nx  = state;
      pred_nx   = pred;
      ref_nx    = ref_word;
      match_nx  = match_cnt;
      miss_nx   = miss_cnt;
      err_nx    = 1'b0;
      period_nx = 1'b0;
      word_inc  = 1'b0;
      err_inc   = 1'b0;
      if (!enable) begin
         state_nx = SEARCH;
         match_nx = '0;
         miss_nx  = '0;
      end else if (rx_vld) begin
         case (state)
            SEARCH: begin
               if (rx_data != '0) begin
                  pred_nx  = next_w(rx_data);
                  match_nx = '0;
                  state_nx = VERIFY;
               end
            end
            VERIFY: begin
               pred_nx = next_w(rx_data);
               if (!mismatch) begin
                  if (match_cnt == LOCK_LAST) begin
                     state_nx = LOCKED;
                     ref_nx   = rx_data;
                     match_nx = '0;
                     miss_nx  = '0;
                  end else begin
                     match_nx = match_cnt + 1'b1;
                  end
               end else begin
                  match_nx = '0;
                  if (rx_data == '0) state_nx = SEARCH;
               end
            end
            LOCKED: begin
               // Flywheel: the prediction never follows the received data once locked.
               pred_nx  = next_w(pred);
               word_inc = 1'b1;
               if (!mismatch) begin
                  miss_nx   = '0;
                  period_nx = (rx_data == ref_word);
               end else begin
                  err_nx  = 1'b1;
                  err_inc = 1'b1;
                  if (miss_cnt == UNLOCK_LAST) begin
                     state_nx = SEARCH;
                     miss_nx  = '0;
                  end else begin
                     miss_nx = miss_cnt + 1'b1;
                  end
               end
            end
            default: state_nx = SEARCH;
         endcase
      end
   end

   // FSM and predictor registers; outputs registered from next-state decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= SEARCH;
         pred        <= '0;
         ref_word    <= '0;
         match_cnt   <= '0;
         miss_cnt    <= '0;
         locked      <= 1'b0;
         err_evt     <= 1'b0;
         period_done <= 1'b0;
      end else begin
         state       <= state_nx;
         pred        <= pred_nx;
         ref_word    <= ref_nx;
         match_cnt   <= match_nx;
         miss_cnt    <= miss_nx;
         locked      <= (state_nx == LOCKED);
         err_evt     <= err_nx;
         period_done <= period_nx;
      end
   end

   // Saturating statistics counters; clear wins over a same-cycle increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_cnt     <= '0;
         word_err_cnt <= '0;
         bit_err_cnt  <= '0;
      end else if (clr_cnt) begin
         word_cnt     <= '0;
         word_err_cnt <= '0;
         bit_err_cnt  <= '0;
      end else begin
         if (word_inc && !(&word_cnt)) word_cnt <= word_cnt + 1'b1;
         if (err_inc && !(&word_err_cnt)) word_err_cnt <= word_err_cnt + 1'b1;
         if (err_inc) bit_err_cnt <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
      end
   end

endmodule

// File: tb/tb_galois_lsfr_checker.sv
// Directed bench for galois_lsfr_checker (8-bit, lock/unlock after 4).
module tb_galois_lsfr_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b1;
   logic        clr_cnt = 1'b0;
   logic        rx_vld = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        locked, err_evt, period_done;
   logic [31:0] word_cnt, word_err_cnt, bit_err_cnt;

   int total = 0;
   int passed = 0;
   int fails = 0;

   typedef struct {
      logic [7:0] data;
      logic       lck;
      logic       err;
      logic       per;
   } exp_t;
   exp_t sb[$];

   logic [7:0] cur;

   galois_lsfr_checker #(.BIT_WIDTH(8), .LOCK_CNT(4), .UNLOCK_CNT(4), .CNT_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .clr_cnt      (clr_cnt),
      .rx_vld       (rx_vld),
      .rx_data      (rx_data),
      .locked       (locked),
      .err_evt      (err_evt),
      .word_cnt     (word_cnt),
      .word_err_cnt (word_err_cnt),
      .bit_err_cnt  (bit_err_cnt),
      .period_done  (period_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // Reference successor for the 8-bit sequence: taps x^8+x^6+x^5+x^4 Galois form.
   function automatic logic [7:0] tb_next(input logic [7:0] b);
      logic [7:0] r;
      r = {b[6:0], b[7]};
      if (b[7]) r = r ^ 8'h70;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one valid word, queue its expected registered response, compare after the edge.
   task automatic send(input logic [7:0] d, input logic l, input logic e, input logic p,
                       input logic clr = 1'b0);
      exp_t x;
      @(negedge clk);
      rx_vld  = 1'b1;
      rx_data = d;
      clr_cnt = clr;
      x.data = d; x.lck = l; x.err = e; x.per = p;
      sb.push_back(x);
      @(posedge clk);
      #1;
      rx_vld  = 1'b0;
      clr_cnt = 1'b0;
      x = sb.pop_front();
      chk($sformatf("locked@%02h", x.data), 64'(locked), 64'(x.lck));
      chk($sformatf("err_evt@%02h", x.data), 64'(err_evt), 64'(x.err));
      chk($sformatf("period_done@%02h", x.data), 64'(period_done), 64'(x.per));
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_cnt(input string tag, input int w, input int we, input int be);
      chk({tag, "_word_cnt"}, 64'(word_cnt), 64'(w));
      chk({tag, "_word_err_cnt"}, 64'(word_err_cnt), 64'(we));
      chk({tag, "_bit_err_cnt"}, 64'(bit_err_cnt), 64'(be));
   endtask

   task automatic do_lock();
      send(8'h01, 1'b0, 1'b0, 1'b0);
      send(8'h02, 1'b0, 1'b0, 1'b0);
      send(8'h04, 1'b0, 1'b0, 1'b0);
      send(8'h08, 1'b0, 1'b0, 1'b0);
      send(8'h10, 1'b1, 1'b0, 1'b0);
      cur = 8'h10;
   endtask

   task automatic send_good();
      cur = tb_next(cur);
      send(cur, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      #1;
      chk("rst_locked", 64'(locked), 64'd0);
      chk("rst_err_evt", 64'(err_evt), 64'd0);
      chk("rst_period", 64'(period_done), 64'd0);
      chk_cnt("rst", 0, 0, 0);
      idle(2);
      @(negedge clk);
      rst = 1'b0;
      idle(1);

      // Lock on 01,02,04,08,10 with a gap in the middle.
      send(8'h01, 1'b0, 1'b0, 1'b0);
      send(8'h02, 1'b0, 1'b0, 1'b0);
      idle(3);
      send(8'h04, 1'b0, 1'b0, 1'b0);
      send(8'h08, 1'b0, 1'b0, 1'b0);
      send(8'h10, 1'b1, 1'b0, 1'b0);
      cur = 8'h10;
      chk_cnt("lock", 0, 0, 0);

      // 20,40,80 good, then FF where 71 is due: FF^71 = 8E, 4 bits.
      send_good();
      send_good();
      send_good();
      cur = tb_next(cur);
      chk("pred_71", 64'(cur), 64'h71);
      send(8'hFF, 1'b1, 1'b1, 1'b0);
      chk_cnt("single_err", 4, 1, 4);
      idle(1);
      chk("err_one_cycle", 64'(err_evt), 64'd0);

      // Correct sequence resumes; flywheel keeps lock without further errors.
      repeat (5) send_good();
      chk_cnt("after_single", 9, 1, 4);

      // Four consecutive single-bit errors drop lock on the fourth.
      @(negedge clk); clr_cnt = 1'b1; @(posedge clk); #1; clr_cnt = 1'b0;
      chk_cnt("clr", 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         cur = tb_next(cur);
         send(cur ^ 8'h01, (i < 3) ? 1'b1 : 1'b0, 1'b1, 1'b0);
      end
      chk_cnt("unlock", 4, 4, 4);
      send(8'h00, 1'b0, 1'b0, 1'b0);

      // Resync and run a full period: 80 -> 71 matches, ref word 10 returns at word 255.
      @(negedge clk); clr_cnt = 1'b1; @(posedge clk); #1; clr_cnt = 1'b0;
      do_lock();
      for (int i = 1; i <= 255; i++) begin
         cur = tb_next(cur);
         send(cur, 1'b1, 1'b0, (i == 255) ? 1'b1 : 1'b0);
      end
      chk("period_word", 64'(cur), 64'h10);
      chk_cnt("period", 255, 0, 0);

      // Error together with clr_cnt: clear wins, event still pulses.
      cur = tb_next(cur);
      send(cur ^ 8'h03, 1'b1, 1'b1, 1'b0, 1'b1);
      chk_cnt("clr_err", 0, 0, 0);
      send_good();
      chk_cnt("post_clr", 1, 0, 0);

      // enable low: unlock, counters hold, no error event on a bad word.
      enable = 1'b0;
      cur = tb_next(cur);
      send(cur ^ 8'hFF, 1'b0, 1'b0, 1'b0);
      chk_cnt("disabled", 1, 0, 0);
      @(negedge clk); enable = 1'b1;

      // Relock, accumulate some stats, then reset mid-lock.
      do_lock();
      send_good();
      cur = tb_next(cur);
      send(cur ^ 8'h80, 1'b1, 1'b1, 1'b0);
      chk_cnt("prerst", 3, 1, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_locked", 64'(locked), 64'd0);
      chk("midrst_err", 64'(err_evt), 64'd0);
      chk_cnt("midrst", 0, 0, 0);
      idle(1);
      @(negedge clk); rst = 1'b0;
      send(8'h00, 1'b0, 1'b0, 1'b0);
      send(8'h00, 1'b0, 1'b0, 1'b0);
      send(8'h00, 1'b0, 1'b0, 1'b0);
      cur = tb_next(cur);
      send(cur, 1'b0, 1'b0, 1'b0);
      send(tb_next(cur), 1'b0, 1'b0, 1'b0);
      chk_cnt("post_rst", 0, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/galois_lsfr_checker.md
GALOIS_LSFR_CHECKER -- requirements
Module: galois_lsfr_checker

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8: word width; legal values 3..20, 32, 64, 128.
REQ-002 SHALL have parameter LOCK_CNT, default 4: consecutive predicted matches required to lock (>=1).
REQ-003 SHALL have parameter UNLOCK_CNT, default 4: consecutive mismatches while locked that drop lock (>=1).
REQ-004 SHALL have parameter CNT_W, default 32: width of all statistics counters.
REQ-005 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port enable, input, 1: checker run; low forces SEARCH and holds counters.
REQ-008 SHALL have port clr_cnt, input, 1: synchronous clear of all statistics counters.
REQ-009 SHALL have port rx_vld, input, 1: rx_data valid this cycle.
REQ-010 SHALL have port rx_data, input, BIT_WIDTH: received Galois LFSR word.
REQ-011 SHALL have port locked, output, 1: checker synchronised to the sequence.
REQ-012 SHALL have port err_evt, output, 1: one-cycle pulse per mismatched word while locked.
REQ-013 SHALL have port word_cnt, output, CNT_W: words checked while locked.
REQ-014 SHALL have port word_err_cnt, output, CNT_W: mismatched words while locked.
REQ-015 SHALL have port bit_err_cnt, output, CNT_W: sum of differing bits while locked.
REQ-016 SHALL have port period_done, output, 1: one-cycle pulse when the locked sequence returns to its lock-reference word.

Function
REQ-017 SHALL compute next(d) as: bit0 = d[W-1]; bit k (1..W-1) = d[k-1] XOR (TAP[k] AND d[W-1]).
REQ-018 SHALL implement states SEARCH, VERIFY, LOCKED; only words with rx_vld=1 advance the FSM; gaps in rx_vld are legal.
REQ-019 SEARCH: on a valid nonzero word, pred <= next(rx_data), match count <= 0, go to VERIFY; all-zero words stay in SEARCH.
REQ-020 VERIFY: rx_data==pred -> pred <= next(rx_data), match count +1; on the LOCK_CNT-th consecutive match go to LOCKED and latch rx_data as lock-reference word.
REQ-021 VERIFY: mismatch -> reseed pred <= next(rx_data), match count <= 0; all-zero mismatch returns to SEARCH.
REQ-022 LOCKED: pred <= next(pred) on every valid word (flywheel, never reseeded), so isolated errors do not propagate.
REQ-023 LOCKED: match clears miss count; mismatch pulses err_evt, increments word_err_cnt, adds popcount(rx_data XOR pred) to bit_err_cnt, increments miss count.
REQ-024 LOCKED: the UNLOCK_CNT-th consecutive mismatch -> SEARCH, locked low the next cycle; that word is still counted.
REQ-025 LOCKED: every valid word increments word_cnt; a matching word equal to the lock-reference word pulses period_done.
REQ-026 All outputs SHALL be registered; err_evt, period_done and counters update 1 cycle after the rx_vld sample.
REQ-027 Counters SHALL saturate at all-ones; clr_cnt has priority over a same-cycle increment.
REQ-028 enable=0 SHALL force SEARCH, deassert locked, and hold counters (clr_cnt still acts).
REQ-029 locked SHALL be high exactly while the FSM is in LOCKED.

Reset
REQ-030 rst SHALL asynchronously force SEARCH, pred=0, match/miss counts=0, lock-reference=0, locked=0, err_evt=0, period_done=0, all counters=0.
REQ-031 Reset asserted mid-lock SHALL discard lock; after release a full SEARCH/VERIFY sequence is required.

Structure
REQ-032 Package SHALL hold state enum and tap-mask function TAP(W), bits set: 3:{2} 4:{3} 5:{3} 6:{5} 7:{6} 8:{6,5,4} 9:{5} 10:{7} 11:{9} 12:{6,4,1} 13:{4,3,1} 14:{5,3,1} 15:{14} 16:{15,13,4} 17:{14} 18:{11} 19:{6,2,1} 20:{17} 32:{22,2,1} 64:{63,61,60} 128:{126,101,99}.
REQ-033 Package SHALL provide the next() function; unsupported BIT_WIDTH SHALL be an elaboration error.
REQ-034 One sub-module, lsfr_popcount (BIT_WIDTH in, clog2(BIT_WIDTH+1) out, combinational), SHALL compute the bit-error count.

Verification (BIT_WIDTH=8, LOCK_CNT=4, UNLOCK_CNT=4)
REQ-035 Feed 01,02,04,08,10 -> locked rises 1 cycle after 10; counters 0.
REQ-036 Locked, feed 80 then 71 -> no err_evt; feed FF instead of 71 -> err_evt 1 cycle, word_err_cnt=1, bit_err_cnt=4 (FF^71=8E).
REQ-037 Locked, single corrupted word then correct sequence -> exactly one error, locked stays high.
REQ-038 Locked, 4 consecutive wrong words -> locked low after 4th, word_err_cnt=4; resync via REQ-035.
REQ-039 Run 255 valid words after lock -> period_done pulses once, word_cnt=255; clr_cnt with error same cycle -> counters 0.
REQ-040 rst mid-lock and all-zero input -> all outputs 0, remains in SEARCH.
